// File: rtl/rx_core_cfg_seq_if.sv
// rx_core_cfg_seq_if
// Register-side bus of the rx_core configuration sequencer.
//   cfg_wr_en   : shadow write strobe, one write per cycle
//   cfg_addr    : shadow register address (0..7 valid, 8..15 rejected)
//   cfg_wr_data : write data, gain registers use bits [7:0]
//   cfg_commit  : single-cycle request to apply the shadow bank
//   busy        : sequencer is running a commit
//   done        : one-cycle pulse when the sequencer returns to idle
//   cfg_err     : one-cycle pulse the cycle after a write to a bad address
// master = register interface side, slave = sequencer side.
interface rx_core_cfg_seq_if;
    logic        cfg_wr_en;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wr_data;
    logic        cfg_commit;
    logic        busy;
    logic        done;
    logic        cfg_err;

    modport master (
        output cfg_wr_en,
        output cfg_addr,
        output cfg_wr_data,
        output cfg_commit,
        input  busy,
        input  done,
        input  cfg_err
    );

    modport slave (
        input  cfg_wr_en,
        input  cfg_addr,
        input  cfg_wr_data,
        input  cfg_commit,
        output busy,
        output done,
        output cfg_err
    );
endinterface

// File: rtl/rx_core_cfg_seq.sv
// rx_core_cfg_seq
// Configuration sequencer for rx_core. Software writes a shadow bank of five
// NCO phase increments and three DUC gains at any time; a commit applies the
// bank glitch-free: gains are muted, the phase increments swap in one cycle,
// the sequencer waits a settle time, then gains ramp to their new values.
// A commit that changes no phase increment skips straight to the gain ramp.
// Ports:
//   clock, reset         : system clock, asynchronous active-high reset
//   bus (slave)          : register-side write/commit bus plus busy/done/cfg_err
//   *_phase_inc [15:0]   : active phase increments driven into rx_core
//   gain_duc1..3 [7:0]   : active DUC gains driven into rx_core
module rx_core_cfg_seq #(
    parameter int RAMP_DIV      = 16,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic               clock,
    input  logic               reset,
    rx_core_cfg_seq_if.slave   bus,
    output logic [15:0]        ddc_phase_inc,
    output logic [15:0]        demix_phase_inc,
    output logic [15:0]        duc1_phase_inc,
    output logic [15:0]        duc2_phase_inc,
    output logic [15:0]        duc3_phase_inc,
    output logic [7:0]         gain_duc1,
    output logic [7:0]         gain_duc2,
    output logic [7:0]         gain_duc3
);

    localparam int CNT_MAX = (RAMP_DIV > SETTLE_CYCLES) ? RAMP_DIV : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, MUTE, LOAD, SETTLE, RAMP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pending;

    logic [15:0] sh_phase  [5];
    logic [7:0]  sh_gain   [3];
    logic [15:0] tgt_phase [5];
    logic [7:0]  tgt_gain  [3];
    logic [15:0] phase     [5];
    logic [7:0]  gain      [3];

    logic [15:0] nxt_phase [5];
    logic [7:0]  nxt_gain  [3];
    logic [7:0]  mute_step [3];
    logic [7:0]  ramp_step [3];

    logic phase_differs;
    logic gains_zero;
    logic mute_zero_next;
    logic at_target;
    logic ramp_done_next;
    logic commit_req;
    logic tick;
    logic settle_end;

    assign ddc_phase_inc   = phase[0];
    assign demix_phase_inc = phase[1];
    assign duc1_phase_inc  = phase[2];
    assign duc2_phase_inc  = phase[3];
    assign duc3_phase_inc  = phase[4];
    assign gain_duc1       = gain[0];
    assign gain_duc2       = gain[1];
    assign gain_duc3       = gain[2];

    assign commit_req = bus.cfg_commit || pending;
    assign tick       = (cnt == CNT_W'(RAMP_DIV - 1));
    assign settle_end = (cnt == CNT_W'(SETTLE_CYCLES - 1));

    // Shadow bank with this cycle's write already applied, so a commit in
    // the same cycle as a write captures the freshly written value.
    always_comb begin
        nxt_phase = sh_phase;
        nxt_gain  = sh_gain;
        if (bus.cfg_wr_en) begin
            case (bus.cfg_addr)
                4'd0:    nxt_phase[0] = bus.cfg_wr_data;
                4'd1:    nxt_phase[1] = bus.cfg_wr_data;
                4'd2:    nxt_phase[2] = bus.cfg_wr_data;
                4'd3:    nxt_phase[3] = bus.cfg_wr_data;
                4'd4:    nxt_phase[4] = bus.cfg_wr_data;
                4'd5:    nxt_gain[0]  = bus.cfg_wr_data[7:0];
                4'd6:    nxt_gain[1]  = bus.cfg_wr_data[7:0];
                4'd7:    nxt_gain[2]  = bus.cfg_wr_data[7:0];
                default: ;
            endcase
        end
    end

    // Next gain values for a mute tick and a ramp tick, plus the
    // all-channel conditions that end MUTE and RAMP.
    always_comb begin
        phase_differs  = 1'b0;
        gains_zero     = 1'b1;
        mute_zero_next = 1'b1;
        at_target      = 1'b1;
        ramp_done_next = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (nxt_phase[i] != phase[i]) phase_differs = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            mute_step[i] = (gain[i] != 8'd0) ? gain[i] - 8'd1 : 8'd0;
            if (gain[i] < tgt_gain[i])
                ramp_step[i] = gain[i] + 8'd1;
            else if (gain[i] > tgt_gain[i])
                ramp_step[i] = gain[i] - 8'd1;
            else
                ramp_step[i] = gain[i];
            if (gain[i] != 8'd0)            gains_zero     = 1'b0;
            if (mute_step[i] != 8'd0)       mute_zero_next = 1'b0;
            if (gain[i] != tgt_gain[i])     at_target      = 1'b0;
            if (ramp_step[i] != tgt_gain[i]) ramp_done_next = 1'b0;
        end
    end

    // Shadow registers and the bad-address error pulse; writes are accepted
    // in every state so software never has to wait for the sequencer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) sh_phase[i] <= 16'h0000;
            for (int i = 0; i < 3; i++) sh_gain[i]  <= 8'h00;
            bus.cfg_err <= 1'b0;
        end else begin
            sh_phase    <= nxt_phase;
            sh_gain     <= nxt_gain;
            bus.cfg_err <= bus.cfg_wr_en && bus.cfg_addr[3];
        end
    end

    // Sequencer FSM. The counter restarts on every state entry; it paces
    // gain ticks in MUTE/RAMP and the settle wait. Phase increments are only
    // written in LOAD, one cycle after the gains are known to be zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pending  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                tgt_phase[i] <= 16'h0000;
                phase[i]     <= 16'h0000;
            end
            for (int i = 0; i < 3; i++) begin
                tgt_gain[i] <= 8'h00;
                gain[i]     <= 8'h00;
            end
        end else begin
            bus.done <= 1'b0;
            if (bus.cfg_commit && (state != IDLE)) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (commit_req) begin
                        pending   <= 1'b0;
                        tgt_phase <= nxt_phase;
                        tgt_gain  <= nxt_gain;
                        cnt       <= '0;
                        bus.busy  <= 1'b1;
                        state     <= phase_differs ? MUTE : RAMP;
                    end
                end

                MUTE: begin
                    if (gains_zero) begin
                        cnt   <= '0;
                        state <= LOAD;
                    end else if (tick) begin
                        gain <= mute_step;
                        cnt  <= '0;
                        if (mute_zero_next) state <= LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LOAD: begin
                    phase <= tgt_phase;
                    cnt   <= '0;
                    state <= SETTLE;
                end

                SETTLE: begin
                    if (settle_end) begin
                        cnt   <= '0;
                        state <= RAMP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RAMP: begin
                    if (at_target) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end else if (tick) begin
                        gain <= ramp_step;
                        cnt  <= '0;
                        if (ramp_done_next) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    cnt      <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
